speed_uart_formatter: RTL
=========================

Name: speed_uart_formatter

Overview:
- Sits directly upstream of uart_tx in the speed-detection path.
- Accepts a binary speed measurement and converts it to ASCII decimal with a sequential double-dabble.
- Streams a fixed-format text line ("SPD=<n> km/h\r\n") to uart_tx one byte at a time using uart_tx's start/done handshake.
- Replaces the hardcoded test-string driver with real measurement reporting.

Parameters:
- SPEED_W, 16, width of i_speed; the digit count is fixed at 5, so SPEED_W is at most 16.
- SPEED_LIMIT, 60, overspeed threshold; used only when OVERSPEED_FLAG_EN is defined.

Ports:
- i_clock  in  1  system clock, shared with uart_tx.
- i_reset  in  1  synchronous, active-high reset.
- i_speed_valid  in  1  one-cycle strobe; i_speed is valid this cycle.
- i_speed  in  SPEED_W  unsigned speed in km/h.
- o_tx_start  out  1  one-cycle pulse requesting uart_tx to send o_tx_data.
- o_tx_data  out  8  byte to transmit; held stable from the start pulse through the done pulse.
- i_tx_done  in  1  one-cycle pulse from uart_tx when a byte has finished.
- o_busy  out  1  high from capture until the last byte's i_tx_done.
- o_overrun  out  1  one-cycle pulse when the pending measurement is overwritten.

Behaviour:
- Reset values: o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_overrun=0, FSM=IDLE, pending slot empty, byte index=0.
- States:
  - IDLE: waits for i_speed_valid or a filled pending slot.
  - CONVERT: exactly 16 cycles of double-dabble (shift plus add-3) producing 5 BCD digits.
  - LOAD: selects the byte at the current index and drives o_tx_data.
  - SEND: o_tx_start=1 for one cycle.
  - WAIT_DONE: holds until i_tx_done.
  - NEXT: advances the index; goes to LOAD, or to IDLE after the last byte.
- Latency: capture on the edge where i_speed_valid=1 in IDLE. The first o_tx_start is high in the 18th cycle after that edge (16 CONVERT + LOAD + SEND).
- Message byte order:
  - "S","P","D","="
  - decimal digits with leading zeros suppressed; at least one digit is always sent; internal zeros are kept (105 gives "105").
  - " ","k","m","/","h"
  - 8'h0D, 8'h0A
- Digit ASCII is 8'h30 + BCD.
- Message length is 12 to 16 bytes (17 with the flag enabled).
- Leading-zero handling: the first-significant-digit position is computed once at the end of CONVERT; it is not recomputed per byte.
- Measurement arriving while busy:
  - stored in a one-deep pending slot;
  - if the slot is already full, the new value overwrites it and o_overrun pulses on the following cycle.
- Same-cycle events:
  - i_speed_valid in the same cycle that the final NEXT returns to IDLE: the value goes to pending and is serviced next.
  - pending non-empty in IDLE: capture it on the next cycle and clear the slot.
- i_tx_done outside WAIT_DONE is ignored. This covers a stale done pulse after reset while uart_tx finishes an in-flight byte.
- i_tx_done in the same cycle as SEND is impossible by protocol; it is ignored.
- Reset mid-message:
  - next cycle the FSM is IDLE and pending is cleared;
  - o_tx_start stays 0, with no partial restart;
  - the remaining bytes of the message are not sent.
- i_speed wider than 16 bits is not supported. The FSM never stalls in CONVERT; its length is constant.

Optional Feature:
- Macro: OVERSPEED_FLAG_EN.
- Defined: the block latches a comparator result i_speed > SPEED_LIMIT at capture. When set, "!" (8'h21) is inserted after "h" and before CR LF; the comparison is strict.
- Undefined: the comparator and extra byte are absent; the message is never 17 bytes.

Decomposition:
- Package speed_uart_pkg holds:
  - the FSM state enum;
  - ASCII constants (prefix "SPD=", suffix " km/h", CR, LF, "!", ASCII_ZERO);
  - NUM_DIGITS=5;
  - CONVERT_CYCLES=16.
- One sub-module, bin2bcd_seq:
  - ports: start, 16-bit bin in, done pulse, 20-bit BCD out;
  - iterative double-dabble;
  - reusable for future display paths.
- Byte selection, the pending slot and the FSM stay in the top module.

Test Plan:
- i_speed=0, bench answers each start with i_tx_done 10 cycles later -> bytes "SPD=0 km/h\r\n" (12 bytes); o_busy falls in the cycle after the 12th done.
- i_speed=65535 -> "SPD=65535 km/h\r\n" (16 bytes); the first o_tx_start is exactly 18 cycles after the valid edge.
- i_speed=105 -> "SPD=105 km/h\r\n"; verifies the internal zero is kept.
- Overrun:
  - stimulus: valid 30, then valids 40 and 50 during the first message;
  - response: o_overrun pulses once (on the 50 write); second message "SPD=50 km/h\r\n"; 40 never sent.
- Reset mid-message:
  - stimulus: assert i_reset during the 5th WAIT_DONE, then a stray i_tx_done after reset;
  - response: no o_tx_start afterwards, o_busy=0, the stray done is ignored; the next valid of 7 gives a clean "SPD=7 km/h\r\n".
- OVERSPEED_FLAG_EN defined, SPEED_LIMIT=60:
  - 60 -> "SPD=60 km/h\r\n";
  - 61 -> "SPD=61 km/h!\r\n".

Source files
------------

// File: rtl/speed_uart_pkg.sv
// Shared types and constants for the speed-to-ASCII UART formatter.
// Byte layout of a line: "SPD=" <1..5 digits> " km/h" [ "!" ] CR LF.
package speed_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_DONE,
        ST_NEXT
    } state_t;

    localparam int NUM_DIGITS     = 5;
    localparam int CONVERT_CYCLES = 16;
    localparam int BCD_W          = 4 * NUM_DIGITS;
    localparam int PREFIX_LEN     = 4;
    localparam int SUFFIX_LEN     = 5;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_BANG = 8'h21;

    function automatic logic [7:0] prefix_byte(input logic [1:0] i);
        case (i)
            2'd0:    prefix_byte = 8'h53;  // S
            2'd1:    prefix_byte = 8'h50;  // P
            2'd2:    prefix_byte = 8'h44;  // D
            default: prefix_byte = 8'h3D;  // =
        endcase
    endfunction

    function automatic logic [7:0] suffix_byte(input logic [2:0] i);
        case (i)
            3'd0:    suffix_byte = 8'h20;  // space
            3'd1:    suffix_byte = 8'h6B;  // k
            3'd2:    suffix_byte = 8'h6D;  // m
            3'd3:    suffix_byte = 8'h2F;  // /
            default: suffix_byte = 8'h68;  // h
        endcase
    endfunction

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [2:0] count_digits(input logic [BCD_W-1:0] bcd);
        if (bcd[19:16] != 4'd0)      count_digits = 3'd5;
        else if (bcd[15:12] != 4'd0) count_digits = 3'd4;
        else if (bcd[11:8] != 4'd0)  count_digits = 3'd3;
        else if (bcd[7:4] != 4'd0)   count_digits = 3'd2;
        else                         count_digits = 3'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 16-bit binary to 5-digit BCD converter (double-dabble).
// The first shift happens on the start edge, so o_done pulses 16 cycles after start.
module bin2bcd_seq
    import speed_uart_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [15:0]      i_bin,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    localparam logic [3:0] LAST_STEP = 4'(CONVERT_CYCLES - 1);

    logic [15:0] bin_sr;
    logic [3:0]  step;
    logic        active;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bin_sr <= '0;
            o_bcd  <= '0;
            step   <= '0;
            active <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                o_bcd  <= {{(BCD_W-1){1'b0}}, i_bin[15]};
                bin_sr <= {i_bin[14:0], 1'b0};
                step   <= 4'd1;
                active <= 1'b1;
            end else if (active) begin
                {o_bcd, bin_sr} <= {bcd_adjust(o_bcd), bin_sr} << 1;
                step <= step + 4'd1;
                if (step == LAST_STEP) begin
                    active <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/speed_uart_formatter.sv
// Formats a binary speed measurement as "SPD=<n> km/h\r\n" and streams it to uart_tx.
// Optional OVERSPEED_FLAG_EN inserts "!" before CR LF when the speed exceeds SPEED_LIMIT.
module speed_uart_formatter
    import speed_uart_pkg::*;
#(
    parameter int SPEED_W = 16
`ifdef OVERSPEED_FLAG_EN
    , parameter int SPEED_LIMIT = 60
`endif
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_speed_valid,
    input  logic [SPEED_W-1:0] i_speed,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_overrun,
    output state_t             o_dbg_state
);

    // uart_tx handshake: o_tx_start is a single-cycle request with o_tx_data already
    // stable; data is held until i_tx_done, which is only honoured in ST_WAIT_DONE.

    state_t             state, state_nxt;
    logic               pend_valid;
    logic [SPEED_W-1:0] pend_val;
    logic [4:0]         idx;
    logic [2:0]         ndig;
    logic               flag;
    logic               capture;
    logic [SPEED_W-1:0] cap_val;
    logic               bcd_done;
    logic [BCD_W-1:0]   bcd;
    logic [4:0]         last_idx;
    logic               last_byte;
    logic [7:0]         sel_byte;

    assign capture  = (state == ST_IDLE) && (pend_valid || i_speed_valid);
    assign cap_val  = pend_valid ? pend_val : i_speed;
    assign last_idx = 5'd10 + {2'b00, ndig} + {4'b0000, flag};
    assign last_byte = (idx == last_idx);

    bin2bcd_seq u_bin2bcd (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_start (capture),
        .i_bin   (16'(cap_val)),
        .o_done  (bcd_done),
        .o_bcd   (bcd)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (capture) state_nxt = ST_CONVERT;
            ST_CONVERT:   if (bcd_done) state_nxt = ST_LOAD;
            ST_LOAD:      state_nxt = ST_SEND;
            ST_SEND:      state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (i_tx_done) state_nxt = ST_NEXT;
            ST_NEXT:      state_nxt = last_byte ? ST_IDLE : ST_LOAD;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Byte at idx: prefix, significant digits (MSB first), suffix, optional flag, CR LF.
    logic [4:0] rel;
    logic [4:0] tail;
    logic [2:0] dpos;
    logic [4:0] ndig5;
    always_comb begin
        sel_byte = 8'h00;
        rel      = '0;
        tail     = '0;
        dpos     = '0;
        ndig5    = {2'b00, ndig};
        if (idx < 5'(PREFIX_LEN)) begin
            sel_byte = prefix_byte(idx[1:0]);
        end else if (idx < 5'(PREFIX_LEN) + ndig5) begin
            rel      = ndig5 - 5'd1 - (idx - 5'(PREFIX_LEN));
            dpos     = rel[2:0];
            sel_byte = ASCII_ZERO + {4'h0, bcd[4*dpos +: 4]};
        end else begin
            rel = idx - 5'(PREFIX_LEN) - ndig5;
            if (rel < 5'(SUFFIX_LEN)) begin
                sel_byte = suffix_byte(rel[2:0]);
            end else if (flag && rel == 5'(SUFFIX_LEN)) begin
                sel_byte = ASCII_BANG;
            end else begin
                tail     = rel - 5'(SUFFIX_LEN) - {4'b0000, flag};
                sel_byte = (tail == 5'd0) ? ASCII_CR : ASCII_LF;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            idx        <= '0;
            ndig       <= 3'd1;
            flag       <= 1'b0;
            o_tx_data  <= 8'h00;
            o_overrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_overrun <= 1'b0;
            if (capture) begin
                idx <= '0;
`ifdef OVERSPEED_FLAG_EN
                flag <= (32'(cap_val) > 32'(SPEED_LIMIT));
`else
                flag <= 1'b0;
`endif
            end
            if (state == ST_CONVERT && bcd_done) ndig <= count_digits(bcd);
            if (state == ST_LOAD) o_tx_data <= sel_byte;
            if (state == ST_NEXT) idx <= idx + 5'd1;

            // A pending value captured this cycle frees the slot unless a new one lands.
            if (state == ST_IDLE) begin
                if (pend_valid) begin
                    if (i_speed_valid) pend_val <= i_speed;
                    else               pend_valid <= 1'b0;
                end
            end else if (i_speed_valid) begin
                pend_val   <= i_speed;
                pend_valid <= 1'b1;
                if (pend_valid) o_overrun <= 1'b1;
            end
        end
    end

    assign o_tx_start  = (state == ST_SEND);
    assign o_busy      = (state != ST_IDLE) && !(state == ST_NEXT && last_byte);
    assign o_dbg_state = state;

endmodule
